inst_mem_loader: RTL
====================

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 64: instruction-memory capacity in bytes; must be a multiple of 4.
REQ-002 SHALL have parameter ADDR_W, default 32: width of the write address.
REQ-003 SHALL run on one clock; reset is synchronous and active-high.
REQ-004 Port: clock  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: start  input  1  single-cycle pulse that begins a program load.
REQ-007 Port: in_valid  input  1  source presents a byte.
REQ-008 Port: in_data  input  8  program byte, most-significant byte of each word first.
REQ-009 Port: in_last  input  1  qualifies the final byte of the image.
REQ-010 Port: in_ready  output  1  loader accepts a byte this cycle.
REQ-011 Port: wr_en  output  1  one-cycle word write strobe to instruction memory.
REQ-012 Port: wr_addr  output  ADDR_W  byte address of the word; always a multiple of 4.
REQ-013 Port: wr_data  output  32  big-endian word: first received byte in [31:24], last received byte in [7:0].
REQ-014 Port: busy  output  1  load in progress.
REQ-015 Port: done  output  1  image loaded completely.
REQ-016 Port: error  output  1  load aborted.
REQ-017 Port: cpu_hold  output  1  holds the processor in reset while the image is not valid.

Function
REQ-018 SHALL implement states IDLE, RECV, WRITE, DONE and ERR, with all outputs registered.
REQ-019 Byte handshake SHALL occur on a cycle where in_valid and in_ready are both 1; no other cycle consumes a byte.
REQ-020 in_ready SHALL be 1 only in RECV.
REQ-021 IDLE/DONE/ERR + start SHALL go to RECV next cycle, clearing done, error, the byte index and the word address (0), and setting busy=1 and cpu_hold=1.
REQ-022 start SHALL be ignored in RECV and WRITE.
REQ-023 Each accepted byte SHALL shift in as word <= {word[23:0], in_data}, with the byte index incrementing modulo 4.
REQ-024 The 4th byte of a word SHALL move RECV to WRITE; wr_en SHALL be 1 for exactly the one WRITE cycle that follows that handshake.
REQ-025 In that WRITE cycle, wr_addr SHALL be the current word address and wr_data SHALL be the assembled word.
REQ-026 After each write, the word address SHALL advance by 4.
REQ-027 After the write, WRITE SHALL go to DONE if the 4th byte carried in_last, and otherwise to RECV.
REQ-028 in_last on a byte with index 0–2 (partial word) SHALL go to ERR with no write.
REQ-029 In WRITE, if word address + 4 > MEM_BYTES, wr_en SHALL stay 0 and the state SHALL go to ERR (overflow); the memory SHALL never be written out of range.
REQ-030 In DONE: done=1, busy=0, cpu_hold=0.
REQ-031 In ERR: error=1, busy=0, cpu_hold=1.
REQ-032 in_valid gaps in RECV SHALL stall without any state change.

Reset
REQ-033 On reset: state=IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, cpu_hold=1, byte index=0.
REQ-034 Reset SHALL take priority over start and handshakes.
REQ-035 Reset mid-load SHALL abandon the partial word without emitting a write.

Structure
REQ-036 A shared package SHALL hold the state enum and the constant WORD_BYTES=4.
REQ-037 One sub-module, be_word_packer, SHALL hold the byte shift register and the modulo-4 index, and output word_full.

Verification
REQ-038 start, then bytes 20,01,00,05 with last on 05 -> a single wr_en pulse, addr 0, data 0x20010005; then done=1, cpu_hold=0.
REQ-039 Eight bytes AC,01,00,00,20,02,00,0A with last on 0A -> writes (0, 0xAC010000) and (4, 0x2002000A); done=1.
REQ-040 Bytes 20,01,00 with last on 00 -> no wr_en; error=1, cpu_hold=1.
REQ-041 MEM_BYTES=8 and 12 bytes with no last -> writes at 0 and 4, none at 8; error=1.
REQ-042 Reset after 2 bytes, then start and 4 bytes 00,00,00,01 with last -> exactly one write, addr 0, data 0x00000001.
REQ-043 in_valid toggled every other cycle during the 4-byte load of REQ-038 -> identical write; in_ready held 1 throughout RECV.

Source files
------------

// File: rtl/inst_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The state enum is used by the top FSM; WORD_BYTES sizes the word packing and address stride.
package inst_mem_loader_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StWrite,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/inst_mem_loader_if.sv
// Byte-stream input and word-write output of the instruction-memory loader.
// The master side feeds bytes and observes writes; the slave side is the loader.
interface inst_mem_loader_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/be_word_packer.sv
// Big-endian byte packer: keeps the three previously accepted bytes and a modulo-4 index.
// word_next is the word formed with the current byte; word_full flags the 4th byte's handshake.
module be_word_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  in_data,
    output logic [31:0] word_next,
    output logic        word_full
);
    logic [23:0] word_q;
    logic [1:0]  idx_q;

    assign word_next = {word_q, in_data};
    assign word_full = shift_en && (idx_q == 2'd3);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (shift_en) begin
            word_q <= word_next[23:0];
            idx_q  <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a byte-serial program image into instruction memory as big-endian 32-bit words,
// holding the CPU in reset until a complete image has been written.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 64,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    inst_mem_loader_if.slave   bus,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               cpu_hold
);
    localparam int unsigned AW1 = ADDR_W + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] word_addr_q, word_addr_d;
    logic              last_q, last_d;
    logic              in_ready_q;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              busy_q, done_q, error_q, cpu_hold_q;

    logic              handshake;
    logic              clear;
    logic              word_full;
    logic [31:0]       word_next;
    logic [ADDR_W:0]   end_addr;
    logic              fits;

    assign handshake = bus.in_valid && in_ready_q;

    // One extra bit so the range check cannot wrap near the top of the address space.
    assign end_addr = {1'b0, word_addr_q} + AW1'(WORD_BYTES);
    assign fits     = end_addr <= AW1'(MEM_BYTES);

    be_word_packer u_packer (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .shift_en  (handshake),
        .in_data   (bus.in_data),
        .word_next (word_next),
        .word_full (word_full)
    );

    always_comb begin
        state_d     = state_q;
        word_addr_d = word_addr_q;
        last_d      = last_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        clear       = 1'b0;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d     = StRecv;
                    word_addr_d = '0;
                    last_d      = 1'b0;
                    clear       = 1'b1;
                end
            end
            StRecv: begin
                if (handshake) begin
                    if (word_full) begin
                        state_d   = StWrite;
                        last_d    = bus.in_last;
                        wr_addr_d = word_addr_q;
                        wr_data_d = word_next;
                        // Strobe is registered, so the range check is made on entry to WRITE.
                        wr_en_d   = fits;
                    end else if (bus.in_last) begin
                        state_d = StErr;
                    end
                end
            end
            StWrite: begin
                if (!fits) begin
                    state_d = StErr;
                end else begin
                    word_addr_d = word_addr_q + ADDR_W'(WORD_BYTES);
                    state_d     = last_q ? StDone : StRecv;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            word_addr_q <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_hold_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            word_addr_q <= word_addr_d;
            last_q      <= last_d;
            in_ready_q  <= (state_d == StRecv);
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= (state_d == StRecv) || (state_d == StWrite);
            done_q      <= (state_d == StDone);
            error_q     <= (state_d == StErr);
            cpu_hold_q  <= (state_d != StDone);
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign cpu_hold     = cpu_hold_q;

endmodule
